// File: rtl/exec_ctrl_pkg.sv
// Shared encodings for the execute-stage controller.
// Opcode[6:2], funct3, ALU / immediate select codes and FSM states.
package exec_ctrl_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_REG    = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_U    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_MD_WAIT
  } state_e;

  function automatic logic [3:0] alu_of_f3(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [3:0] r;
    r = ALU_ADD;
    unique case (f3)
      F3_ADD:  r = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  r = ALU_SLL;
      F3_SLT:  r = ALU_SLT;
      F3_SLTU: r = ALU_SLTU;
      F3_XOR:  r = ALU_XOR;
      F3_SR:   r = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   r = ALU_OR;
      F3_AND:  r = ALU_AND;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exec_ctrl_unit_decode.sv
// Combinational RV32I decoder for the X stage.
// Mul/div acceptance depends on EXEC_CTRL_MULDIV_EN.
module exec_ctrl_decode
  import exec_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  input  logic        inst_valid,
  input  logic        br_eq,
  input  logic        br_lt,
  output logic [2:0]  imm_sel,
  output logic        br_un,
  output logic        bsel,
  output logic        asel,
  output logic [3:0]  alu_sel,
  output logic        is_branch,
  output logic        br_taken,
  output logic        is_transfer,
  output logic        is_md,
  output logic        illegal
);

  logic [4:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal, md, br, cond, xfer, live;
  logic [2:0] imm_r;
  logic       a_r, b_r, un_r;
  logic [3:0] alu_r;

  assign opc = inst[6:2];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  always_comb begin
    legal = 1'b0;
    md    = 1'b0;
    br    = 1'b0;
    cond  = 1'b0;
    xfer  = 1'b0;
    imm_r = IMM_NONE;
    a_r   = 1'b0;
    b_r   = 1'b0;
    un_r  = 1'b0;
    alu_r = ALU_ADD;
    if (inst[1:0] == 2'b11) begin
      unique case (opc)
        OP_REG: begin
          alu_r = alu_of_f3(f3, inst[30]);
          if (f7 == 7'b0000000) begin
            legal = 1'b1;
          end else if (f7 == 7'b0100000) begin
            legal = (f3 == F3_ADD) || (f3 == F3_SR);
          end else if (f7 == 7'b0000001) begin
`ifdef EXEC_CTRL_MULDIV_EN
            legal = 1'b1;
            md    = 1'b1;
`endif
          end
        end
        OP_IMM: begin
          imm_r = IMM_I;
          b_r   = 1'b1;
          alu_r = alu_of_f3(f3, (f3 == F3_SR) && inst[30]);
          if (f3 == F3_SLL)
            legal = (f7 == 7'b0000000);
          else if (f3 == F3_SR)
            legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          else
            legal = 1'b1;
        end
        OP_LOAD: begin
          imm_r = IMM_I;
          b_r   = 1'b1;
          legal = (f3 != 3'b011) && (f3[2:1] != 2'b11);
        end
        OP_STORE: begin
          imm_r = IMM_S;
          b_r   = 1'b1;
          legal = !f3[2] && (f3 != 3'b011);
        end
        OP_LUI: begin
          imm_r = IMM_U;
          b_r   = 1'b1;
          alu_r = ALU_PASSB;
          legal = 1'b1;
        end
        OP_AUIPC: begin
          imm_r = IMM_U;
          a_r   = 1'b1;
          b_r   = 1'b1;
          legal = 1'b1;
        end
        OP_JAL: begin
          imm_r = IMM_J;
          a_r   = 1'b1;
          b_r   = 1'b1;
          xfer  = 1'b1;
          legal = 1'b1;
        end
        OP_JALR: begin
          imm_r = IMM_I;
          b_r   = 1'b1;
          xfer  = 1'b1;
          legal = (f3 == 3'b000);
        end
        OP_BRANCH: begin
          br    = 1'b1;
          legal = (f3[2:1] != 2'b01);
          un_r  = (f3[2:1] == 2'b11);
          cond  = f3[2] ? (br_lt ^ f3[0]) : (br_eq ^ f3[0]);
          if (cond) begin
            imm_r = IMM_B;
            a_r   = 1'b1;
            b_r   = 1'b1;
            xfer  = 1'b1;
          end
        end
        default: legal = 1'b0;
      endcase
    end
  end

  // NOP and bubbles drive the same idle selects as an illegal slot
  assign live = inst_valid && legal && (inst != INST_NOP);

  assign imm_sel     = live ? imm_r : IMM_NONE;
  assign alu_sel     = live ? alu_r : ALU_ADD;
  assign asel        = live && a_r;
  assign bsel        = live && b_r;
  assign br_un       = live && un_r;
  assign is_branch   = live && br;
  assign br_taken    = live && br && cond;
  assign is_transfer = live && xfer;
  assign is_md       = live && md;
  assign illegal     = inst_valid && !legal;

endmodule

// File: rtl/exec_ctrl_unit.sv
// Execute-stage control: decode, redirect/squash FSM, branch counters.
// EXEC_CTRL_MULDIV_EN adds the multi-cycle mul/div stall path.
module exec_ctrl_unit
  import exec_ctrl_pkg::*;
#(
  parameter int KILL_DEPTH = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_x,
  input  logic             inst_valid,
  input  logic             br_eq,
  input  logic             br_lt,
  output logic [2:0]       imm_sel,
  output logic             br_un,
  output logic             bsel,
  output logic             asel,
  output logic [3:0]       alu_sel,
  output logic             redirect,
  output logic             latch_x_en,
  output logic             latch_w_en,
  output logic             stall,
  output logic             illegal,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] br_taken_cnt,
  output logic             md_req,
  output logic [2:0]       md_op,
  input  logic             md_done
);

  localparam int KW = (KILL_DEPTH > 2) ? $clog2(KILL_DEPTH) : 1;

  state_e            state_q, state_d;
  logic [KW-1:0]     kill_q, kill_d;
  logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]  tk_cnt_q, tk_cnt_d;
  logic              d_branch, d_taken, d_xfer, d_md, d_illegal;

  exec_ctrl_decode u_dec (
    .inst        (inst_x),
    .inst_valid  (inst_valid),
    .br_eq       (br_eq),
    .br_lt       (br_lt),
    .imm_sel     (imm_sel),
    .br_un       (br_un),
    .bsel        (bsel),
    .asel        (asel),
    .alu_sel     (alu_sel),
    .is_branch   (d_branch),
    .br_taken    (d_taken),
    .is_transfer (d_xfer),
    .is_md       (d_md),
    .illegal     (d_illegal)
  );

`ifndef EXEC_CTRL_MULDIV_EN
  logic [1:0] unused_md;
  assign unused_md = {md_done, d_md};
`endif

  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    br_cnt_d   = br_cnt_q;
    tk_cnt_d   = tk_cnt_q;
    redirect   = 1'b0;
    latch_x_en = 1'b1;
    latch_w_en = 1'b1;
    stall      = 1'b0;
    md_req     = 1'b0;
    md_op      = 3'b000;
    unique case (state_q)
      ST_RUN: begin
        if (d_branch) begin
          br_cnt_d = br_cnt_q + CNT_W'(1);
          if (d_taken) tk_cnt_d = tk_cnt_q + CNT_W'(1);
        end
        if (d_xfer) begin
          redirect   = 1'b1;
          latch_x_en = 1'b0;
          latch_w_en = !d_branch;
          if (KILL_DEPTH > 1) begin
            state_d = ST_FLUSH;
            kill_d  = KW'(KILL_DEPTH - 2);
          end
`ifdef EXEC_CTRL_MULDIV_EN
        end else if (d_md) begin
          md_req     = 1'b1;
          md_op      = inst_x[14:12];
          stall      = 1'b1;
          latch_x_en = 1'b0;
          latch_w_en = 1'b0;
          state_d    = ST_MD_WAIT;
`endif
        end
      end
      ST_FLUSH: begin
        latch_x_en = 1'b0;
        if (kill_q == '0) state_d = ST_RUN;
        else kill_d = kill_q - KW'(1);
      end
      ST_MD_WAIT: begin
`ifdef EXEC_CTRL_MULDIV_EN
        if (md_done) begin
          state_d = ST_RUN;
        end else begin
          md_req     = 1'b1;
          md_op      = inst_x[14:12];
          stall      = 1'b1;
          latch_x_en = 1'b0;
          latch_w_en = 1'b0;
        end
`else
        state_d = ST_RUN;
`endif
      end
      default: state_d = ST_RUN;
    endcase
  end

  // a squashed slot never raises a trap
  assign illegal      = d_illegal && (state_q != ST_FLUSH);
  assign br_cnt       = br_cnt_q;
  assign br_taken_cnt = tk_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      kill_q   <= '0;
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      kill_q   <= kill_d;
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
    end
  end

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Directed self-checking bench for exec_ctrl_unit (KILL_DEPTH=3, CNT_W=4).
// Mul/div steps run only when EXEC_CTRL_MULDIV_EN is defined.
module tb_exec_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_x;
  logic        inst_valid, br_eq, br_lt, md_done;
  logic [2:0]  imm_sel, md_op;
  logic        br_un, bsel, asel, redirect;
  logic        latch_x_en, latch_w_en, stall, illegal, md_req;
  logic [3:0]  alu_sel, br_cnt, br_taken_cnt;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] I_ADDI = 32'h0050_0093;
  localparam logic [31:0] I_SUB  = 32'h4000_0033;
  localparam logic [31:0] I_SRAI = 32'h4030_D093;
  localparam logic [31:0] I_LW   = 32'h0000_A083;
  localparam logic [31:0] I_SW   = 32'h0010_A023;
  localparam logic [31:0] I_LUI  = 32'h0000_10B7;
  localparam logic [31:0] I_AUIP = 32'h0000_1097;
  localparam logic [31:0] I_BEQ  = 32'h0000_0463;
  localparam logic [31:0] I_BNE  = 32'h0000_1463;
  localparam logic [31:0] I_BLTU = 32'h0000_6463;
  localparam logic [31:0] I_JAL  = 32'h0100_00EF;
  localparam logic [31:0] I_NOP  = 32'h0000_0013;
  localparam logic [31:0] I_MUL  = 32'h0220_8033;
  localparam logic [31:0] I_BAD  = 32'hFFFF_FFFF;

  exec_ctrl_unit #(.KILL_DEPTH(3), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_x       (inst_x),
    .inst_valid   (inst_valid),
    .br_eq        (br_eq),
    .br_lt        (br_lt),
    .imm_sel      (imm_sel),
    .br_un        (br_un),
    .bsel         (bsel),
    .asel         (asel),
    .alu_sel      (alu_sel),
    .redirect     (redirect),
    .latch_x_en   (latch_x_en),
    .latch_w_en   (latch_w_en),
    .stall        (stall),
    .illegal      (illegal),
    .br_cnt       (br_cnt),
    .br_taken_cnt (br_taken_cnt),
    .md_req       (md_req),
    .md_op        (md_op),
    .md_done      (md_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] i,
                     input logic eq, input logic lt);
    inst_valid = v;
    inst_x     = i;
    br_eq      = eq;
    br_lt      = lt;
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic r,
                         input logic lx, input logic lw);
    chk({tag, ".redirect"}, {31'b0, redirect}, {31'b0, r});
    chk({tag, ".latch_x"}, {31'b0, latch_x_en}, {31'b0, lx});
    chk({tag, ".latch_w"}, {31'b0, latch_w_en}, {31'b0, lw});
  endtask

  task automatic chk_sel(input string tag, input logic [2:0] im,
                         input logic a, input logic b, input logic [3:0] al);
    chk({tag, ".imm"}, {29'b0, imm_sel}, {29'b0, im});
    chk({tag, ".asel"}, {31'b0, asel}, {31'b0, a});
    chk({tag, ".bsel"}, {31'b0, bsel}, {31'b0, b});
    chk({tag, ".alu"}, {28'b0, alu_sel}, {28'b0, al});
  endtask

  initial begin
    rst = 1'b1;
    md_done = 1'b0;
    drv(1'b0, I_NOP, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk_ctl("reset", 1'b0, 1'b1, 1'b1);
    chk("reset.stall", {31'b0, stall}, 32'd0);
    chk("reset.md_req", {31'b0, md_req}, 32'd0);
    chk("reset.br_cnt", {28'b0, br_cnt}, 32'd0);
    chk("reset.tk_cnt", {28'b0, br_taken_cnt}, 32'd0);
    chk_sel("bubble", 3'b111, 1'b0, 1'b0, 4'b0000);

    drv(1'b1, I_ADDI, 1'b0, 1'b0);
    chk_sel("addi", 3'b000, 1'b0, 1'b1, 4'b0000);
    chk_ctl("addi", 1'b0, 1'b1, 1'b1);
    drv(1'b1, I_SUB, 1'b0, 1'b0);
    chk_sel("sub", 3'b111, 1'b0, 1'b0, 4'b0001);
    drv(1'b1, I_SRAI, 1'b0, 1'b0);
    chk_sel("srai", 3'b000, 1'b0, 1'b1, 4'b0111);
    drv(1'b1, I_LW, 1'b0, 1'b0);
    chk_sel("lw", 3'b000, 1'b0, 1'b1, 4'b0000);
    drv(1'b1, I_SW, 1'b0, 1'b0);
    chk_sel("sw", 3'b001, 1'b0, 1'b1, 4'b0000);
    drv(1'b1, I_LUI, 1'b0, 1'b0);
    chk_sel("lui", 3'b011, 1'b0, 1'b1, 4'b1010);
    drv(1'b1, I_AUIP, 1'b0, 1'b0);
    chk_sel("auipc", 3'b011, 1'b1, 1'b1, 4'b0000);
    drv(1'b1, I_NOP, 1'b0, 1'b0);
    chk_sel("nop", 3'b111, 1'b0, 1'b0, 4'b0000);
    chk("nop.illegal", {31'b0, illegal}, 32'd0);
    tick();

    drv(1'b1, I_BEQ, 1'b1, 1'b0);
    chk_sel("beq_t", 3'b010, 1'b1, 1'b1, 4'b0000);
    chk_ctl("beq_t", 1'b1, 1'b0, 1'b0);
    tick();
    chk("beq_t.br_cnt", {28'b0, br_cnt}, 32'd1);
    chk("beq_t.tk_cnt", {28'b0, br_taken_cnt}, 32'd1);
    drv(1'b1, I_BEQ, 1'b1, 1'b0);
    chk_ctl("flush1", 1'b0, 1'b0, 1'b1);
    tick();
    drv(1'b1, I_JAL, 1'b0, 1'b0);
    chk_ctl("flush2_jal", 1'b0, 1'b0, 1'b1);
    tick();
    drv(1'b0, I_NOP, 1'b0, 1'b0);
    chk_ctl("post_flush", 1'b0, 1'b1, 1'b1);
    chk("flush.br_cnt", {28'b0, br_cnt}, 32'd1);
    chk("flush.tk_cnt", {28'b0, br_taken_cnt}, 32'd1);

    drv(1'b1, I_BLTU, 1'b0, 1'b0);
    chk("bltu.br_un", {31'b0, br_un}, 32'd1);
    chk_sel("bltu_nt", 3'b111, 1'b0, 1'b0, 4'b0000);
    chk_ctl("bltu_nt", 1'b0, 1'b1, 1'b1);
    tick();
    chk("bltu.br_cnt", {28'b0, br_cnt}, 32'd2);
    chk("bltu.tk_cnt", {28'b0, br_taken_cnt}, 32'd1);

    drv(1'b1, I_JAL, 1'b0, 1'b0);
    chk_sel("jal", 3'b100, 1'b1, 1'b1, 4'b0000);
    chk_ctl("jal", 1'b1, 1'b0, 1'b1);
    tick();
    drv(1'b0, I_NOP, 1'b0, 1'b0);
    chk_ctl("jal.f1", 1'b0, 1'b0, 1'b1);
    tick();
    chk_ctl("jal.f2", 1'b0, 1'b0, 1'b1);
    tick();
    chk_ctl("jal.run", 1'b0, 1'b1, 1'b1);
    chk("jal.br_cnt", {28'b0, br_cnt}, 32'd2);

    drv(1'b1, I_BAD, 1'b1, 1'b1);
    chk("bad.illegal", {31'b0, illegal}, 32'd1);
    chk_ctl("bad", 1'b0, 1'b1, 1'b1);
    chk_sel("bad", 3'b111, 1'b0, 1'b0, 4'b0000);
    drv(1'b0, I_BAD, 1'b1, 1'b1);
    chk("bad_bubble.illegal", {31'b0, illegal}, 32'd0);
    tick();
    chk("bad.br_cnt", {28'b0, br_cnt}, 32'd2);

    drv(1'b1, I_BNE, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) tick();
    chk("wrap.br_cnt15", {28'b0, br_cnt}, 32'd15);
    tick();
    chk("wrap.br_cnt0", {28'b0, br_cnt}, 32'd0);
    chk("wrap.tk_cnt", {28'b0, br_taken_cnt}, 32'd1);

`ifdef EXEC_CTRL_MULDIV_EN
    drv(1'b1, I_MUL, 1'b0, 1'b0);
    chk("mul.illegal", {31'b0, illegal}, 32'd0);
    chk("mul.op", {29'b0, md_op}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk("mul.stall", {31'b0, stall}, 32'd1);
      chk("mul.md_req", {31'b0, md_req}, 32'd1);
      chk_ctl("mul.wait", 1'b0, 1'b0, 1'b0);
      tick();
    end
    md_done = 1'b1;
    #1;
    chk("done.stall", {31'b0, stall}, 32'd0);
    chk("done.md_req", {31'b0, md_req}, 32'd0);
    chk("done.latch_w", {31'b0, latch_w_en}, 32'd1);
    tick();
    md_done = 1'b0;
    drv(1'b0, I_NOP, 1'b0, 1'b0);
    chk("after.stall", {31'b0, stall}, 32'd0);
    drv(1'b1, I_MUL, 1'b0, 1'b0);
    tick();
    chk("wait2.md_req", {31'b0, md_req}, 32'd1);
    rst = 1'b1;
    drv(1'b0, I_NOP, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_wait.md_req", {31'b0, md_req}, 32'd0);
    chk("rst_wait.stall", {31'b0, stall}, 32'd0);
    chk("rst_wait.tk_cnt", {28'b0, br_taken_cnt}, 32'd0);
`else
    drv(1'b1, I_MUL, 1'b0, 1'b0);
    chk("mul.illegal", {31'b0, illegal}, 32'd1);
    chk("mul.md_req", {31'b0, md_req}, 32'd0);
    chk("mul.stall", {31'b0, stall}, 32'd0);
    tick();
    chk_ctl("mul.next", 1'b0, 1'b1, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_ctrl_unit.md
# exec_ctrl_unit

Execute-stage control for the RV32I pipeline, next generation of the X-stage controller. Decodes the instruction in X into ALU/immediate/operand selects, resolves branches from `br_eq`/`br_lt`, drives the fetch redirect, and squashes a parametrised number of younger pipeline slots. A registered state machine replaces ad-hoc latch enables, adds branch statistics, and optionally stalls for a multi-cycle mul/div unit.

## Interface
- `KILL_DEPTH`, 1: number of consecutive cycles `latch_x_en` is held low after a redirect (≥1).
- `CNT_W`, 16: width of branch statistics counters.
- `clk` in 1: pipeline clock.
- `rst` in 1: synchronous, active-high reset.
- `inst_x` in 32: instruction currently in X.
- `inst_valid` in 1: `inst_x` is a live instruction; 0 = bubble.
- `br_eq`, `br_lt` in 1 each: branch comparator results for `inst_x`.
- `imm_sel` out 3: 000 I, 001 S, 010 B, 011 U, 100 J, 111 none.
- `br_un` out 1: 1 = unsigned compare (BLTU/BGEU only).
- `bsel` out 1: 1 = immediate; `asel` out 1: 1 = PC.
- `alu_sel` out 4: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 srl, 0111 sra, 1000 slt, 1001 sltu, 1010 passB.
- `redirect` out 1: fetch takes ALU result as next PC.
- `latch_x_en`, `latch_w_en` out 1: enables of the X and W pipeline latches.
- `stall` out 1: hold F/D latches and PC.
- `illegal` out 1: unsupported encoding in X.
- `br_cnt`, `br_taken_cnt` out `CNT_W`: valid branches resolved / taken.
- `md_req` out 1, `md_op` out 3, `md_done` in 1: mul/div handshake (macro only).

## Operation
- Decode (combinational): R, I-arith (incl. SLLI/SRLI/SRAI → `bsel`=1, alu 0101/0110/0111), loads/stores (alu add, `bsel`=1, imm I/S), LUI (imm U, passB), AUIPC (imm U, `asel`=1, add), JAL (imm J, `asel`=1, `bsel`=1, add), JALR (imm I, `bsel`=1, add), branches. RV32I funct3 encodings (LW=010, SW=010, etc.). Bit 30 selects SUB/SRA.
- Taken branch: imm 010, `asel`=`bsel`=1, add; not taken: imm 111, selects 0. BEQ `br_eq`; BNE `!br_eq`; BLT/BLTU `br_lt`; BGE/BGEU `!br_lt`.
- Bubble (`inst_valid`=0), NOP, or illegal: imm 111, other selects 0, no redirect, no state change; `illegal` only when `inst_valid`=1.
- States: RUN, FLUSH, MD_WAIT.
- RUN: transfer (taken branch, JAL, JALR) → `redirect`=1, `latch_x_en`=0, `latch_w_en`=0 for branch / 1 for JAL/JALR; next state FLUSH if `KILL_DEPTH`>1 (counter=`KILL_DEPTH`-2) else RUN.
- FLUSH: `latch_x_en`=0, `latch_w_en`=1, `redirect`=0, `inst_x` ignored; counter decrements, RUN when 0.
- Counters: in RUN, valid branch increments `br_cnt`; taken also `br_taken_cnt`. Wrap modulo 2^`CNT_W`. Not counted in FLUSH.

## Timing
- Decode, `redirect`, `latch_*_en`, `stall`, `illegal` combinational from `inst_x`, branch inputs and registered state; state/counters update on `posedge clk`.
- Redirect is a single-cycle pulse; squash lasts exactly `KILL_DEPTH` cycles including the redirect cycle.
- Reset: state RUN, counters 0, `redirect`=0, `latch_x_en`=`latch_w_en`=1, `stall`=0, `md_req`=0. Reset during FLUSH/MD_WAIT aborts to RUN on that edge.
- Transfer in X during FLUSH is ignored (it is a squashed slot).

## Configuration
- `EXEC_CTRL_MULDIV_EN` defined: R-type with funct7=0000001 in RUN → MD_WAIT next cycle; in entry cycle and MD_WAIT, `md_req`=1, `md_op`=funct3, `stall`=1, `latch_x_en`=0, `latch_w_en`=0. Cycle with `md_done`=1: `md_req`=0, `stall`=0, `latch_w_en`=1, next RUN. `md_done` outside MD_WAIT ignored.
- Undefined: funct7=0000001 flags `illegal`; `md_req`/`md_op` tied 0, MD_WAIT unreachable.

## Structure
- Package `exec_ctrl_pkg`: opcode[6:2] constants, funct3 constants, ALU and imm_sel codes, state enum.
- Sub-module `exec_ctrl_decode`: pure combinational decoder (selects, branch-taken, is_transfer, is_md, illegal); FSM and counters in top.

## Test plan
- Reset, then `addi` (0x00500093) → imm 000, `bsel`=1, alu 0000, `redirect`=0, both latches 1.
- `beq` with `br_eq`=1, `KILL_DEPTH`=3 → `redirect` 1 cycle, `latch_x_en` low 3 cycles, `latch_w_en` low 1 cycle, `br_taken_cnt`=1.
- `bltu` with `br_lt`=0 → not taken, `br_un`=1, `br_cnt`+1, `br_taken_cnt` unchanged.
- `jal` in X during FLUSH → no redirect, no count; `jal` in RUN → `latch_w_en`=1, `redirect`=1.
- Macro on: `mul` (0x02208033), `md_done` after 4 cycles → `stall`/`md_req` high 5 cycles, `md_op`=000; `rst` mid-wait → RUN, `md_req`=0 next cycle.
- 0xFFFFFFFF valid → `illegal`=1, no redirect; `br_cnt` wraps at 2^`CNT_W` to 0.
